// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low matrix keypad scanner: synchronizes columns, classifies each full
// scan, debounces press/release and emits a registered 5-bit key code plus strobe.
module keypad_scan_encoder #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [4:0] key_code,
  output logic       key_strobe,
  output logic       key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [4:0]  CODE_IDLE = 5'b11111;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DEB,
    HELD,
    RELEASE_DEB
  } state_t;

  state_t             state, state_nx;
  logic [3:0]         col_meta, col_sync;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         row_idx;
  logic               sample_tick, scan_done;
  logic [3:0]         row_keys;
  logic [11:0]        scan_acc;
  logic [15:0]        valid_keys;
  logic [1:0]         key_cnt;
  logic [3:0]         key_idx;
  logic               res_none, res_single;
  logic [3:0]         cand, cand_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [4:0]         code_nx;
  logic               strobe_nx;

  function automatic logic [4:0] encode(input logic [3:0] k);
    logic [4:0] c;
    case (k)
      4'd10:   c = 5'b11100;
      4'd11:   c = 5'b11110;
      4'd12:   c = 5'b11000;
      default: c = {1'b0, k};
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  assign sample_tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_done   = sample_tick && (row_idx == 2'd3);
  assign row_keys    = ~col_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      row_idx <= 2'd0;
      row_n   <= 4'b1110;
    end else if (sample_tick) begin
      div_cnt <= '0;
      row_idx <= row_idx + 2'd1;
      row_n   <= {row_n[2:0], row_n[3]};
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Rows 0..2 are stored; row 3 is merged live so the result is ready on its sample cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_acc <= '0;
    end else if (scan_done) begin
      scan_acc <= '0;
    end else if (sample_tick) begin
      case (row_idx)
        2'd0:    scan_acc[3:0]  <= row_keys;
        2'd1:    scan_acc[7:4]  <= row_keys;
        2'd2:    scan_acc[11:8] <= row_keys;
        default: scan_acc       <= scan_acc;
      endcase
    end
  end

  assign valid_keys = {row_keys, scan_acc} & 16'h1FFF;

  always_comb begin
    key_cnt = 2'd0;
    key_idx = 4'd0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (valid_keys[i]) begin
        if (key_cnt != 2'd2) key_cnt = key_cnt + 2'd1;
        key_idx = 4'(i);
      end
    end
  end

  assign res_none   = (key_cnt == 2'd0);
  assign res_single = (key_cnt == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      key_code   <= CODE_IDLE;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_nx;
      cand       <= cand_nx;
      cnt        <= cnt_nx;
      key_code   <= code_nx;
      key_strobe <= strobe_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    cnt_nx    = cnt;
    code_nx   = key_code;
    strobe_nx = 1'b0;
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (res_single) begin
            cand_nx  = key_idx;
            cnt_nx   = CNT_W'(1);
            state_nx = PRESS_DEB;
          end
        end
        PRESS_DEB: begin
          if (res_single && key_idx == cand) begin
            if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
              state_nx  = HELD;
              code_nx   = encode(cand);
              strobe_nx = 1'b1;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end else if (res_single) begin
            cand_nx = key_idx;
            cnt_nx  = CNT_W'(1);
          end else begin
            state_nx = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            cnt_nx   = CNT_W'(1);
            state_nx = RELEASE_DEB;
          end
        end
        RELEASE_DEB: begin
          if (res_none) begin
            if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
              state_nx = IDLE;
              code_nx  = CODE_IDLE;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end else begin
            state_nx = HELD;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    key_held = (state == HELD) || (state == RELEASE_DEB);
  end

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
- Scans a 4x4 active-low matrix keypad, synchronizes and debounces it, and encodes the result into the 5-bit key code consumed by the timer/display controller.
- This block is the producer end of that key-code interface. The controller treats 5'b11111 as idle and any other value as a held key.
- The output is a level code plus a one-cycle strobe per accepted press.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven low; legal minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; legal minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- col_n  in  4  keypad column inputs (pulled up; low = key closed on the driven row); asynchronous
- row_n  out  4  keypad row drive, exactly one bit low at a time
- key_code  out  5  encoded key: 5'b11111 idle; digit d (0..9) = {1'b0,d[3:0]}; START = 5'b11100; RESET = 5'b11110; TIMING = 5'b11000
- key_strobe  out  1  one-cycle pulse when key_code changes to a newly accepted key
- key_held  out  1  high while a key is accepted (HELD or RELEASE_DEB states)

Behaviour:
- Reset (async assert, sync release):
  - row_n=4'b1110, key_code=5'b11111, key_strobe=0, key_held=0.
  - State IDLE; all counters and the accumulated scan cleared.
- Synchronization: col_n passes through a 2-flop synchronizer before any use.
- Row scan:
  - Row r is driven low for SCAN_DIV cycles, in the order r = 0,1,2,3,0,...
  - Synchronized columns are sampled on the last cycle of each row slot.
- Key index: k = 4*r + c, where c is the low column bit. Map:
  - k 0..9: digits 0..9.
  - k 10: START. k 11: RESET. k 12: TIMING.
  - k 13..15: unused, ignored (treated as not pressed).
- Scan result: evaluated once per full scan, after the row 3 sample. It is one of:
  - NONE: zero valid keys.
  - SINGLE(k): exactly one valid key.
  - MULTI: two or more valid keys.
- FSM, updated only on a scan result:
  - IDLE:
    - SINGLE(k): cand=k, cnt=1, go to PRESS_DEB.
    - NONE or MULTI: stay.
  - PRESS_DEB:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, go to HELD, key_code<=code(cand), key_strobe=1 for the next cycle only.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: cnt=1, go to RELEASE_DEB.
    - Any other result (same key, different key, MULTI): stay HELD; key_code unchanged (no rollover).
  - RELEASE_DEB:
    - NONE: cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE, key_code<=5'b11111.
    - Anything else: return to HELD, no strobe.
- Latency:
  - Press accept: key_code updates 1 cycle after the completing scan's row 3 sample.
  - Minimum press-to-code time: DEBOUNCE_SCANS*4*SCAN_DIV cycles plus synchronizer delay.
- key_strobe never asserts on release, on re-entry to HELD, or while in HELD.
- key_code only changes on the IDLE->HELD path (new code) and the RELEASE_DEB->IDLE path (5'b11111). It is glitch-free (registered).
- Reset mid-operation:
  - Outputs return to reset values immediately.
  - A key still closed after reset release must pass a full press debounce before it is re-reported.
- Counter widths: sized for SCAN_DIV-1 and DEBOUNCE_SCANS; no wrap occurs within legal parameter ranges.

Test Plan:
- All tests use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (one full scan = 16 cycles).
- Reset/idle: no key pressed -> row_n cycles 1110,1101,1011,0111 for 4 cycles each; key_code=11111, key_strobe=0, key_held=0 indefinitely.
- Digit press/release: close k=5 (row1, col1) stable -> after 3 scans key_code=00101 with exactly one key_strobe pulse and key_held=1; open it -> after 3 NONE scans key_code=11111, key_held=0, no strobe.
- Bounce rejection: toggle k=7 closed/open every scan for 10 scans -> key_code stays 11111, no strobe. Then hold k=7 stable -> key_code=00111 after 3 scans.
- Function keys and unused keys:
  - k=10 -> 11100; k=11 -> 11110; k=12 -> 11000, each with one strobe.
  - k=14 held for 10 scans -> no change, no strobe.
- Multi-key:
  - Close k=0 and k=3 together -> no strobe, key_code=11111.
  - Hold k=3 until accepted (00011), then also close k=0 -> key_code stays 00011.
  - Release both -> 11111.
- Reset mid-HELD:
  - Hold k=9 until key_code=01001, then pulse rst_n low for 2 cycles with k=9 still closed -> key_code=11111 and row_n=1110 immediately.
  - After release of reset, key_code returns to 01001 with a new strobe after 3 scans.
